matrix_operand_loader: RTL

Serial-to-parallel front end for the combinational 4x4 matrix multiplier. It accepts matrix elements one per handshake over a valid/ready stream and assembles operand matrices A and B. It then presents both matrices, held stable, to the downstream multiplier and keeps them stable until the consumer acknowledges. The block owns all sequencing, so the multiplier stays purely combinational.

---
 rtl/matrix_operand_loader_if.sv | 27 ++
 rtl/matrix_operand_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/matrix_operand_loader_if.sv
// Stream-in / matrix-out bundle between the operand loader, its element
// source and the downstream combinational matrix multiplier.
interface matrix_operand_loader_if #(
  parameter int DW = 4,
  parameter int N  = 4
);
  localparam int CW = $clog2(2*N*N) + 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [DW-1:0]               in_data;
  logic                        mat_valid;
  logic                        mat_ready;
  logic [N-1:0][N-1:0][DW-1:0] a_out;     // [row][col]
  logic [N-1:0][N-1:0][DW-1:0] b_out;     // [row][col]
  logic [CW-1:0]               load_cnt;

  modport slave (
    input  in_valid, in_data, mat_ready,
    output in_ready, mat_valid, a_out, b_out, load_cnt
  );

  modport master (
    output in_valid, in_data, mat_ready,
    input  in_ready, mat_valid, a_out, b_out, load_cnt
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader: collects 2*N*N elements into matrices
// A then B and holds them stable for a combinational multiplier until acked.

// One stored matrix element; written only on its own transfer slot.
module matrix_operand_loader_elem #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module matrix_operand_loader #(
  parameter int DW = 4,
  parameter int N  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  matrix_operand_loader_if.slave  bus
);
  localparam int NN = N*N;
  localparam int NE = 2*NN;
  localparam int CW = $clog2(NE) + 1;
  localparam logic [CW-1:0] LAST_A = CW'(NN-1);
  localparam logic [CW-1:0] LAST_B = CW'(NE-1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mat_valid_q, mat_valid_d;
  logic                xfer;
  logic [NE-1:0][DW-1:0] elem_q;

  // Ready depends on state alone so upstream never sees a valid->ready path.
  assign bus.in_ready = (state_q != HOLD);
  assign xfer         = bus.in_valid && bus.in_ready && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      mat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mat_valid_q <= mat_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_A) state_d = LOAD_B;
        end
        LOAD_B: if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_B) state_d = HOLD;
        end
        HOLD: if (bus.mat_ready) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
    mat_valid_d = (state_d == HOLD);
  end

  // Element e owns transfer slot e; A occupies slots 0..NN-1, B the rest.
  for (genvar e = 0; e < NE; e++) begin : g_elem
    localparam logic [CW-1:0] IDX = CW'(e);
    matrix_operand_loader_elem #(.DW(DW)) u_elem (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (xfer && (cnt_q == IDX)),
      .d_i   (bus.in_data),
      .q_o   (elem_q[e])
    );
  end

  // Flat slot k maps to bits k*DW, which is row-major [k/N][k%N].
  assign bus.a_out     = elem_q[NN-1:0];
  assign bus.b_out     = elem_q[NE-1:NN];
  assign bus.mat_valid = mat_valid_q;
  assign bus.load_cnt  = cnt_q;
endmodule
